trap_controller: RTL and testbench

//  Commit-side exception initiator for the CSR file: samples exception flags on the committing

---
 rtl/trap_pkg.sv | 20 ++
 rtl/trap_controller_if.sv | 33 +++
 rtl/trap_prio_enc.sv | 24 ++
 rtl/trap_controller.sv | 120 ++++++++++++
 tb/tb_trap_controller.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the commit-side trap controller.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

  localparam int CAUSE_W = 5;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 5'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 5'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 5'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL    = 5'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_OVERFLOW = 5'd4;

  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0100;

endpackage

// File: rtl/trap_controller_if.sv
// Commit, CSR and fetch-redirect signals of the trap controller.
interface trap_controller_if #(
  parameter int NUM_SRC = 4
);
  logic                        commit_valid;
  logic [31:0]                 commit_pc;
  logic [NUM_SRC-1:0]          commit_exc;
  logic                        commit_eret;
  logic [31:0]                 epc;
  logic                        exception_sig;
  logic [31:0]                 exception_pc;
  logic [trap_pkg::CAUSE_W-1:0] exception_cause;
  logic                        flush;
  logic                        commit_stall;
  // Redirect handshake: a transfer happens on a rising edge where redirect_valid and
  // redirect_ready are both high; redirect_pc is stable whenever redirect_valid is high,
  // and redirect_valid never drops before that transfer.
  logic                        redirect_valid;
  logic [31:0]                 redirect_pc;
  logic                        redirect_ready;

  modport master (
    output commit_valid, commit_pc, commit_exc, commit_eret, epc, redirect_ready,
    input  exception_sig, exception_pc, exception_cause, flush, commit_stall,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, commit_exc, commit_eret, epc, redirect_ready,
    output exception_sig, exception_pc, exception_cause, flush, commit_stall,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_prio_enc.sv
// Lowest-index-wins encoder: source bit i maps to cause code i+1.
module trap_prio_enc
  import trap_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               hit,
  output logic [CAUSE_W-1:0] cause
);

  // Scanning downward lets the lowest set index overwrite the others.
  always_comb begin
    hit   = 1'b0;
    cause = CAUSE_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit   = 1'b1;
        cause = CAUSE_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Commit-side trap/eret sequencer: IDLE -> FLUSH -> REDIRECT -> IDLE.
// Optional TRAP_STAT_EN adds a free-running trap_count output.
module trap_controller
  import trap_pkg::*;
#(
  parameter int          NUM_SRC      = 4,
  parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  trap_controller_if.slave    bus,
  output trap_state_e         dbg_state
`ifdef TRAP_STAT_EN
  ,
  output logic [31:0]         trap_count
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  trap_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        target_q, target_d;
  logic               exc_sig_q, exc_sig_d;
  logic [31:0]        exc_pc_q, exc_pc_d;
  logic [CAUSE_W-1:0] exc_cause_q, exc_cause_d;

  logic               enc_hit;
  logic [CAUSE_W-1:0] enc_cause;

  trap_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req   (bus.commit_exc),
    .hit   (enc_hit),
    .cause (enc_cause)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    exc_sig_d   = 1'b0;
    exc_pc_d    = exc_pc_q;
    exc_cause_d = exc_cause_q;
    case (state_q)
      ST_IDLE: begin
        // An exception on the same commit as an eret takes priority.
        if (bus.commit_valid && enc_hit) begin
          exc_sig_d   = 1'b1;
          exc_pc_d    = bus.commit_pc;
          exc_cause_d = enc_cause;
          target_d    = HANDLER_ADDR;
          cnt_d       = CNT_W'(FLUSH_CYCLES);
          state_d     = ST_FLUSH;
        end else if (bus.commit_valid && bus.commit_eret) begin
          target_d = bus.epc;
          cnt_d    = CNT_W'(FLUSH_CYCLES);
          state_d  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_REDIRECT: begin
        if (bus.redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      target_q    <= '0;
      exc_sig_q   <= 1'b0;
      exc_pc_q    <= '0;
      exc_cause_q <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      exc_sig_q   <= exc_sig_d;
      exc_pc_q    <= exc_pc_d;
      exc_cause_q <= exc_cause_d;
    end
  end

  assign bus.exception_sig   = exc_sig_q;
  assign bus.exception_pc    = exc_pc_q;
  assign bus.exception_cause = exc_cause_q;
  assign bus.flush           = (state_q == ST_FLUSH);
  assign bus.redirect_valid  = (state_q == ST_REDIRECT);
  assign bus.redirect_pc     = target_q;
  assign bus.commit_stall    = (state_q != ST_IDLE);
  assign dbg_state           = state_q;

`ifdef TRAP_STAT_EN
  logic [31:0] count_q, count_d;

  // Counts on the same edge that raises exception_sig, so both update together.
  always_comb begin
    count_d = count_q;
    if (exc_sig_d) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign trap_count = count_q;
`endif

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed scenarios plus random commits against a
// transaction-level reference model.
module tb_trap_controller;
  import trap_pkg::*;

  localparam int          NUM_SRC      = 4;
  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] HANDLER      = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  trap_controller_if #(.NUM_SRC(NUM_SRC)) bus ();
  trap_state_e dbg_state;
`ifdef TRAP_STAT_EN
  logic [31:0] trap_count;
`endif

  trap_controller #(
    .NUM_SRC      (NUM_SRC),
    .HANDLER_ADDR (HANDLER),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef TRAP_STAT_EN
    ,
    .trap_count(trap_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a sequence is "busy" for age 1..FLUSH_CYCLES flushing, then
  // redirecting until a ready is seen; each accepted trap queues its {cause, pc}.
  logic [36:0] exp_q[$];
  bit          m_busy;
  int          m_age;
  logic [31:0] m_target;
  logic [31:0] m_pc;
  logic [4:0]  m_cause;
  logic [31:0] m_count;

  function automatic int lowest_cause(input logic [NUM_SRC-1:0] e);
    for (int i = 0; i < NUM_SRC; i++) if (e[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_target = '0; m_pc = '0; m_cause = '0; m_count = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [31:0] pc, input logic [NUM_SRC-1:0] exc,
                            input bit eret, input logic [31:0] epc, input bit rdy);
    if (!m_busy) begin
      if (v && exc != '0) begin
        m_busy = 1; m_age = 1;
        m_pc = pc; m_cause = 5'(lowest_cause(exc)); m_target = HANDLER;
        m_count = m_count + 32'd1;
        exp_q.push_back({m_cause, m_pc});
      end else if (v && eret) begin
        m_busy = 1; m_age = 1; m_target = epc;
      end
    end else if (m_age > FLUSH_CYCLES && rdy) begin
      m_busy = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic compare_outputs();
    logic [36:0] rec;
    bit          exp_redir;
    exp_redir = m_busy && (m_age > FLUSH_CYCLES);
    check("exc_sig", bus.exception_sig, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      rec = exp_q.pop_front();
      check("exc_record", {bus.exception_cause, bus.exception_pc}, rec);
    end
    check("exc_pc_hold", bus.exception_pc, m_pc);
    check("exc_cause_hold", bus.exception_cause, m_cause);
    check("flush", bus.flush, m_busy && (m_age <= FLUSH_CYCLES));
    check("redirect_valid", bus.redirect_valid, exp_redir);
    if (exp_redir) check("redirect_pc", bus.redirect_pc, m_target);
    check("commit_stall", bus.commit_stall, m_busy);
    check("dbg_busy", dbg_state != ST_IDLE, m_busy);
`ifdef TRAP_STAT_EN
    check("trap_count", trap_count, m_count);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sig"}, bus.exception_sig, 0);
    check({tag, "_pc"}, bus.exception_pc, 0);
    check({tag, "_cause"}, bus.exception_cause, 0);
    check({tag, "_flush"}, bus.flush, 0);
    check({tag, "_rvalid"}, bus.redirect_valid, 0);
    check({tag, "_rpc"}, bus.redirect_pc, 0);
    check({tag, "_stall"}, bus.commit_stall, 0);
    check({tag, "_idle"}, dbg_state == ST_IDLE, 1);
`ifdef TRAP_STAT_EN
    check({tag, "_count"}, trap_count, 0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, let the rising edge sample, compare at the next falling edge.
  task automatic step(input bit v, input logic [31:0] pc, input logic [NUM_SRC-1:0] exc,
                      input bit eret, input logic [31:0] epc, input bit rdy);
    bus.commit_valid   = v;
    bus.commit_pc      = pc;
    bus.commit_exc     = exc;
    bus.commit_eret    = eret;
    bus.epc            = epc;
    bus.redirect_ready = rdy;
    @(negedge clk);
    model_step(v, pc, exc, eret, epc, rdy);
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 32'h0, '0, 0, 32'h0, rdy);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check_all_zero("reset");
    model_reset();
    bus.commit_valid = 0; bus.commit_exc = '0; bus.commit_eret = 0; bus.redirect_ready = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.commit_valid = 0; bus.commit_pc = '0; bus.commit_exc = '0;
    bus.commit_eret = 0; bus.epc = '0; bus.redirect_ready = 0;
    model_reset();
    #1;
    check_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ECALL at 0x40, redirect held until ready
    step(1, 32'h40, 4'b0100, 0, 32'h0, 0);
    idle(4, 0);
    idle(2, 1);
    // bit1 beats bit3
    step(1, 32'h44, 4'b1010, 0, 32'h0, 0);
    idle(4, 1);
    // eret to epc
    step(1, 32'h48, 4'b0000, 1, 32'h80, 0);
    idle(4, 1);
    // exception wins over eret
    step(1, 32'h4c, 4'b0001, 1, 32'h200, 0);
    idle(4, 1);
    // flags without commit_valid are ignored
    step(0, 32'h50, 4'b1111, 1, 32'h300, 1);
    idle(1, 1);
    // long stall with new faulting commits during it
    step(1, 32'h54, 4'b1000, 0, 32'h0, 0);
    idle(2, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h99, 4'b0001, 1, 32'h400, 0);
    idle(2, 1);
    // reset during FLUSH
    step(1, 32'h58, 4'b0010, 0, 32'h0, 0);
    apply_reset();
    idle(2, 1);
    // three traps counted, then reset clears
    for (int t = 0; t < 3; t++) begin
      step(1, 32'h60 + 32'(t * 4), 4'b0001 << t, 0, 32'h0, 1);
      idle(4, 1);
    end
    apply_reset();
    idle(1, 1);

    // random commits
    for (int i = 0; i < 600; i++) begin
      logic [NUM_SRC-1:0] exc;
      exc = ($urandom_range(0, 2) == 0) ? NUM_SRC'($urandom_range(1, 15)) : '0;
      step($urandom_range(0, 2) == 0, $urandom, exc, $urandom_range(0, 1) == 1,
           $urandom, $urandom_range(0, 1) == 1);
    end
    idle(6, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
